// File: rtl/irq_controller.sv
// N-channel interrupt controller: synchronise, latch, mask and encode requests.
// Latency: irq_in sampled at edge E0 -> edge pending bit after E2; level bit after E1.
// No backpressure: strobes act on the edge they are sampled, outputs are registers or comb of registers.
module irq_controller #(
  parameter int N_IRQ  = 8,
  parameter int IDX_W  = $clog2(N_IRQ),
  parameter int VEC_W  = 8,
  parameter bit ROTATE = 1'b0
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic [N_IRQ-1:0]  level_mode,
  input  logic [N_IRQ-1:0]  masks_in,
  input  logic              masks_wrt_n,
  input  logic              vector_wrt_n,
  input  logic              int_ack,
  input  logic              clear_all,
  input  logic              int_enable,
  output logic [N_IRQ-1:0]  irq_status,
  output logic [N_IRQ-1:0]  irq_masks,
  output logic [VEC_W-1:0]  irq_vector,
  output logic              int_pending
);

  localparam int PW = IDX_W + 1;

  logic [N_IRQ-1:0] s1_q, s2_q, s3_q;
  logic [N_IRQ-1:0] edge_q, edge_d;
  logic [N_IRQ-1:0] masks_q, masks_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] masked;
  logic [N_IRQ-1:0] ack_hit;
  logic [IDX_W-1:0] lat_idx;
  logic [IDX_W-1:0] win_idx;
  logic [PW-1:0]    pos_w;

  // Third synchroniser stage only serves edge detection.
  assign rise    = s2_q & ~s3_q;
  assign lat_idx = vec_q[IDX_W:1];

  // Level channels follow the synchronised line; edge channels read their latch.
  assign irq_status  = (level_mode & s2_q) | (~level_mode & edge_q);
  assign irq_masks   = masks_q;
  assign irq_vector  = vec_q;
  assign masked      = irq_status & masks_q;
  assign int_pending = (|masked) & int_enable;

  // Decode acknowledge against the latched index, never the live winner.
  always_comb begin
    ack_hit = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      ack_hit[i] = int_ack && (lat_idx == IDX_W'(i));
    end
  end

  // Edge latches: clear_all beats a new rise, a new rise beats its own ack.
  always_comb begin
    if (clear_all) begin
      edge_d = '0;
    end else begin
      edge_d = (rise | (edge_q & ~ack_hit)) & ~level_mode;
    end
  end

  // Priority search; iterating from the far end leaves the first hit in search order.
  always_comb begin
    win_idx = '0;
    pos_w   = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      pos_w = (ROTATE ? {1'b0, ptr_q} : '0) + PW'(i);
      if (pos_w >= PW'(N_IRQ)) begin
        pos_w = pos_w - PW'(N_IRQ);
      end
      if (masked[pos_w[IDX_W-1:0]]) begin
        win_idx = pos_w[IDX_W-1:0];
      end
    end
  end

  // Mask write, vector latch and rotation pointer next state; encoder sees the old masks.
  always_comb begin
    masks_d = masks_q;
    if (!masks_wrt_n) begin
      masks_d = masks_in;
    end
    vec_d = vec_q;
    if (!vector_wrt_n) begin
      vec_d          = '0;
      vec_d[IDX_W:1] = win_idx;
    end
    ptr_d = ptr_q;
    if (ROTATE && int_ack) begin
      ptr_d = (lat_idx == IDX_W'(N_IRQ - 1)) ? '0 : lat_idx + 1'b1;
    end
  end

  // State registers; reset clears everything, including in-flight synchroniser bits.
  always_ff @(posedge clk) begin
    if (arst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      edge_q  <= '0;
      masks_q <= '0;
      vec_q   <= '0;
      ptr_q   <= '0;
    end else begin
      s1_q    <= irq_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      edge_q  <= edge_d;
      masks_q <= masks_d;
      vec_q   <= vec_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// Scoreboard bench for irq_controller: fixed-priority and rotating instances share stimulus.
// Expectations are queued with the cycle they fall due; a monitor compares after each edge.
// Inputs change on the falling edge, outputs are sampled 2 time units after the rising edge.
module tb_irq_controller;

  localparam int K_STATUS = 0;
  localparam int K_MASKS  = 1;
  localparam int K_VEC    = 2;
  localparam int K_PEND   = 3;
  localparam int K_RVEC   = 4;
  localparam int K_RSTAT  = 5;

  logic       clk = 1'b0;
  logic       arst;
  logic [7:0] irq_in, level_mode, masks_in;
  logic       masks_wrt_n, vector_wrt_n, int_ack, clear_all, int_enable;

  logic [7:0] f_status, f_masks, f_vector;
  logic       f_pending;
  logic [7:0] r_status, r_masks, r_vector;
  logic       r_pending;

  typedef struct {
    int          due;
    int          kind;
    logic [63:0] exp;
    string       name;
  } item_t;

  item_t sb[$];
  int    cyc   = 0;
  int    total = 0;
  int    bad   = 0;

  always #5 clk = ~clk;

  irq_controller #(.N_IRQ(8), .VEC_W(8), .ROTATE(1'b0)) u_fix (
    .clk(clk), .arst(arst), .irq_in(irq_in), .level_mode(level_mode),
    .masks_in(masks_in), .masks_wrt_n(masks_wrt_n), .vector_wrt_n(vector_wrt_n),
    .int_ack(int_ack), .clear_all(clear_all), .int_enable(int_enable),
    .irq_status(f_status), .irq_masks(f_masks), .irq_vector(f_vector),
    .int_pending(f_pending)
  );

  irq_controller #(.N_IRQ(8), .VEC_W(8), .ROTATE(1'b1)) u_rot (
    .clk(clk), .arst(arst), .irq_in(irq_in), .level_mode(level_mode),
    .masks_in(masks_in), .masks_wrt_n(masks_wrt_n), .vector_wrt_n(vector_wrt_n),
    .int_ack(int_ack), .clear_all(clear_all), .int_enable(int_enable),
    .irq_status(r_status), .irq_masks(r_masks), .irq_vector(r_vector),
    .int_pending(r_pending)
  );

  // Monitor: after each rising edge, compare every expectation that has fallen due.
  initial begin
    item_t       it;
    logic [63:0] act;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        it = sb.pop_front();
        case (it.kind)
          K_STATUS: act = {56'd0, f_status};
          K_MASKS:  act = {56'd0, f_masks};
          K_VEC:    act = {56'd0, f_vector};
          K_PEND:   act = {63'd0, f_pending};
          K_RVEC:   act = {56'd0, r_vector};
          default:  act = {56'd0, r_status};
        endcase
        total++;
        if (act !== it.exp) begin
          bad++;
          $display("FAIL %s (cycle %0d): got %0h expected %0h", it.name, cyc, act, it.exp);
        end
      end
    end
  end

  // Queue an expectation for the state right after the coming rising edge.
  task automatic expect_v(input int k, input logic [63:0] v, input string nm);
    item_t it;
    it.due  = cyc + 1;
    it.kind = k;
    it.exp  = v;
    it.name = nm;
    sb.push_back(it);
  endtask

  task automatic nedge();
    @(negedge clk);
  endtask

  // One-cycle pulse; returns at the falling edge before the edge that sets pending.
  task automatic pulse(input logic [7:0] m);
    irq_in = m;
    nedge();
    irq_in = '0;
    nedge();
  endtask

  task automatic latch(input int k, input logic [7:0] v, input string nm);
    vector_wrt_n = 1'b0;
    expect_v(k, v, nm);
    nedge();
    vector_wrt_n = 1'b1;
  endtask

  task automatic ack(input int k, input logic [7:0] st, input string nm);
    int_ack = 1'b1;
    expect_v(k, st, nm);
    nedge();
    int_ack = 1'b0;
  endtask

  task automatic write_masks(input logic [7:0] m);
    masks_in    = m;
    masks_wrt_n = 1'b0;
    expect_v(K_MASKS, m, "mask_write");
    nedge();
    masks_wrt_n = 1'b1;
  endtask

  initial begin
    arst = 1'b1; irq_in = '0; level_mode = '0; masks_in = '0;
    masks_wrt_n = 1'b1; vector_wrt_n = 1'b1; int_ack = 1'b0;
    clear_all = 1'b0; int_enable = 1'b1;

    // Reset state
    nedge();
    expect_v(K_STATUS, 0, "rst_status");
    expect_v(K_MASKS,  0, "rst_masks");
    expect_v(K_VEC,    0, "rst_vector");
    expect_v(K_PEND,   0, "rst_pending");
    nedge();
    arst = 1'b0;
    write_masks(8'hFF);

    // Single pulse on channel 5: latency and vector encoding
    irq_in = 8'h20;
    expect_v(K_STATUS, 8'h00, "ch5_after_E0");
    nedge();
    irq_in = '0;
    expect_v(K_STATUS, 8'h00, "ch5_after_E1");
    nedge();
    expect_v(K_STATUS, 8'h20, "ch5_after_E2");
    expect_v(K_PEND,   1,     "ch5_pending");
    nedge();
    latch(K_VEC, 8'h0A, "ch5_vector");
    int_ack = 1'b1;
    expect_v(K_STATUS, 8'h00, "ch5_acked");
    expect_v(K_PEND,   0,     "ch5_ack_pending");
    nedge();
    int_ack = 1'b0;

    // Channels 3 and 6 together, fixed priority
    pulse(8'h48);
    expect_v(K_STATUS, 8'h48, "ch36_status");
    nedge();
    latch(K_VEC, 8'h06, "ch36_vec3");
    ack(K_STATUS, 8'h40, "ch36_ack3");
    latch(K_VEC, 8'h0C, "ch36_vec6");
    int_ack = 1'b1;
    expect_v(K_STATUS, 8'h00, "ch36_ack6");
    expect_v(K_PEND,   0,     "ch36_idle");
    nedge();
    int_ack = 1'b0;

    // Level channel 4 ignores ack and clear_all
    level_mode = 8'h10;
    irq_in     = 8'h10;
    expect_v(K_STATUS, 8'h00, "lvl_after_E0");
    nedge();
    expect_v(K_STATUS, 8'h10, "lvl_after_E1");
    nedge();
    latch(K_VEC, 8'h08, "lvl_vector");
    ack(K_STATUS, 8'h10, "lvl_ack_no_effect");
    irq_in = 8'h15;
    nedge();
    irq_in = 8'h10;
    nedge();
    expect_v(K_STATUS, 8'h15, "lvl_plus_edges");
    nedge();
    clear_all = 1'b1;
    expect_v(K_STATUS, 8'h10, "clear_all_edges_only");
    nedge();
    clear_all = 1'b0;
    irq_in    = 8'h00;
    expect_v(K_STATUS, 8'h10, "lvl_drop_E0");
    nedge();
    expect_v(K_STATUS, 8'h00, "lvl_drop_E1");
    nedge();
    level_mode = 8'h00;

    // Masking and global enable
    write_masks(8'h00);
    pulse(8'h01);
    expect_v(K_STATUS, 8'h01, "mask_status");
    expect_v(K_PEND,   0,     "mask_blocks");
    nedge();
    latch(K_VEC, 8'h00, "mask_vec_zero");
    masks_in    = 8'h01;
    masks_wrt_n = 1'b0;
    expect_v(K_PEND, 1, "unmask_pending");
    nedge();
    masks_wrt_n = 1'b1;
    int_enable  = 1'b0;
    expect_v(K_PEND,   0,     "disable_pending");
    expect_v(K_STATUS, 8'h01, "disable_keeps_status");
    nedge();
    int_enable = 1'b1;
    expect_v(K_PEND, 1, "reenable_pending");
    nedge();

    // Rise coincident with ack of the same channel keeps it pending
    masks_in    = 8'hFF;
    masks_wrt_n = 1'b0;
    clear_all   = 1'b1;
    expect_v(K_STATUS, 8'h00, "pre_coinc_clear");
    nedge();
    masks_wrt_n = 1'b1;
    clear_all   = 1'b0;
    pulse(8'h04);
    expect_v(K_STATUS, 8'h04, "coinc_first");
    nedge();
    latch(K_VEC, 8'h04, "coinc_vector");
    pulse(8'h04);
    int_ack = 1'b1;
    expect_v(K_STATUS, 8'h04, "coinc_rise_wins");
    expect_v(K_PEND,   1,     "coinc_pending");
    nedge();
    int_ack = 1'b0;
    ack(K_STATUS, 8'h00, "coinc_plain_ack");

    // Reset while a request is inside the synchroniser
    irq_in = 8'h08;
    nedge();
    irq_in = 8'h00;
    arst   = 1'b1;
    expect_v(K_STATUS, 8'h00, "midsync_rst");
    expect_v(K_MASKS,  8'h00, "midsync_masks");
    nedge();
    arst = 1'b0;
    expect_v(K_STATUS, 8'h00, "midsync_late1");
    nedge();
    expect_v(K_STATUS, 8'h00, "midsync_late2");
    nedge();
    expect_v(K_STATUS, 8'h00, "midsync_late3");
    expect_v(K_PEND,   0,     "midsync_pending");
    nedge();

    // Rotating priority instance
    arst = 1'b1;
    nedge();
    arst = 1'b0;
    write_masks(8'hFF);
    pulse(8'h06);
    expect_v(K_RSTAT, 8'h06, "rot_pend12");
    nedge();
    latch(K_RVEC, 8'h02, "rot_vec_a");
    ack(K_RSTAT, 8'h04, "rot_ack1");
    pulse(8'h02);
    expect_v(K_RSTAT, 8'h06, "rot_retrig1");
    nedge();
    latch(K_RVEC, 8'h04, "rot_vec_b");
    ack(K_RSTAT, 8'h02, "rot_ack2");
    pulse(8'h04);
    expect_v(K_RSTAT, 8'h06, "rot_retrig2");
    nedge();
    latch(K_RVEC, 8'h02, "rot_vec_c");
    ack(K_RSTAT, 8'h04, "rot_ack1b");
    pulse(8'h81);
    expect_v(K_RSTAT, 8'h85, "rot_pend027");
    nedge();
    latch(K_RVEC, 8'h04, "rot_vec_ch2");
    ack(K_RSTAT, 8'h81, "rot_ack2b");
    latch(K_RVEC, 8'h0E, "rot_vec_ch7");
    ack(K_RSTAT, 8'h01, "rot_ack7");
    clear_all = 1'b1;
    expect_v(K_RSTAT, 8'h00, "rot_clear");
    nedge();
    clear_all = 1'b0;
    pulse(8'h42);
    expect_v(K_RSTAT, 8'h42, "rot_pend16");
    nedge();
    latch(K_RVEC, 8'h02, "rot_wrap_ptr0");

    repeat (3) nedge();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
